// File: rtl/baud_gen_frac_pkg.sv
// Shared constants and reset-divisor helpers for the baud generator and the UART engines.
// The reset divisor is computed at elaboration from clock and baud rate.
package baud_gen_frac_pkg;

   localparam int unsigned OsrDefault   = 16;
   localparam int unsigned DivWDefault  = 16;
   localparam int unsigned FracWDefault = 8;

   function automatic longint unsigned rst_div_int(input longint unsigned clk_freq,
                                                   input longint unsigned baud,
                                                   input longint unsigned osr);
      return clk_freq / (baud * osr);
   endfunction

   function automatic longint unsigned rst_div_frac(input longint unsigned clk_freq,
                                                    input longint unsigned baud,
                                                    input longint unsigned osr,
                                                    input longint unsigned frac_w);
      longint unsigned p;
      p = baud * osr;
      return ((clk_freq % p) << frac_w) / p;
   endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// Control/status bundle between the register block (master) and the baud generator (slave).
interface baud_gen_frac_if #(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned FRAC_W = 8
);
   logic              enable;
   logic              cfg_load;
   logic [DIV_W-1:0]  cfg_div_int;
   logic [FRAC_W-1:0] cfg_div_frac;
   logic              restart;
   logic              os_tick;
   logic              mid_tick;
   logic              bit_tick;
   logic              cfg_pending;

   modport master (
      output enable, cfg_load, cfg_div_int, cfg_div_frac, restart,
      input  os_tick, mid_tick, bit_tick, cfg_pending
   );

   modport slave (
      input  enable, cfg_load, cfg_div_int, cfg_div_frac, restart,
      output os_tick, mid_tick, bit_tick, cfg_pending
   );
endinterface

// File: rtl/baud_gen_frac_tick_div.sv
// Fractional clock divider: cycle counter plus phase accumulator; term_o flags the
// terminal edge of each oversample period (combinational, registered by the caller).
module baud_gen_frac_tick_div #(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned FRAC_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_i,
   input  logic              restart_i,
   input  logic [DIV_W-1:0]  div_int_i,
   input  logic [FRAC_W-1:0] div_frac_i,
   output logic              term_o
);
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              extend_q, extend_d;
   logic [DIV_W-1:0]  div_eff;
   logic [DIV_W-1:0]  term_cnt;
   logic [FRAC_W:0]   sum;
   logic              ext_ok;

   assign div_eff  = (div_int_i < DIV_W'(2)) ? DIV_W'(2) : div_int_i;
   assign ext_ok   = (div_eff != {DIV_W{1'b1}});
   assign term_cnt = div_eff - DIV_W'(1) + DIV_W'(extend_q);
   assign sum      = {1'b0, acc_q} + {1'b0, div_frac_i};
   assign term_o   = enable_i && !restart_i && (cnt_q == term_cnt);

   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      extend_d = extend_q;
      if (restart_i) begin
         cnt_d    = '0;
         acc_d    = '0;
         extend_d = 1'b0;
      end else if (enable_i) begin
         if (term_o) begin
            cnt_d    = '0;
            acc_d    = sum[FRAC_W-1:0];
            // Carry out of the accumulator stretches the next period by one cycle.
            extend_d = sum[FRAC_W] && ext_ok;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         extend_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         extend_q <= extend_d;
      end
   end
endmodule

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional baud generator: oversample, mid-bit and bit ticks,
// with a shadowed divisor that takes effect only on a period boundary.
module baud_gen_frac
   import baud_gen_frac_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned OSR       = OsrDefault,
   parameter int unsigned DIV_W     = DivWDefault,
   parameter int unsigned FRAC_W    = FracWDefault
) (
   input  logic           clk,
   input  logic           reset_n,
   baud_gen_frac_if.slave bus
);
   localparam int unsigned OsCntW = $clog2(OSR);
   localparam logic [DIV_W-1:0] RstInt =
      DIV_W'(rst_div_int(longint'(CLK_FREQ), longint'(BAUD_RATE), longint'(OSR)));
   localparam logic [FRAC_W-1:0] RstFrac =
      FRAC_W'(rst_div_frac(longint'(CLK_FREQ), longint'(BAUD_RATE), longint'(OSR),
                           longint'(FRAC_W)));
   localparam logic [OsCntW-1:0] OsLast = OsCntW'(OSR - 1);
   localparam logic [OsCntW-1:0] OsMid  = OsCntW'(OSR / 2 - 1);

   logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
   logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
   logic [DIV_W-1:0]  act_int_q, act_int_d;
   logic [FRAC_W-1:0] act_frac_q, act_frac_d;
   logic              pending_q, pending_d;
   logic [OsCntW-1:0] os_cnt_q, os_cnt_d;
   logic              os_tick_q, os_tick_d;
   logic              mid_tick_q, mid_tick_d;
   logic              bit_tick_q, bit_tick_d;
   logic              term;
   logic              copy;

   baud_gen_frac_tick_div #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W)
   ) u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable_i   (bus.enable),
      .restart_i  (bus.restart),
      .div_int_i  (act_int_q),
      .div_frac_i (act_frac_q),
      .term_o     (term)
   );

   // The period in progress finishes on the old divisor; the swap lands on its terminal edge.
   assign copy = pending_q && (term || bus.restart || !bus.enable);

   always_comb begin
      shadow_int_d  = shadow_int_q;
      shadow_frac_d = shadow_frac_q;
      act_int_d     = act_int_q;
      act_frac_d    = act_frac_q;
      pending_d     = pending_q;
      if (copy) begin
         act_int_d  = shadow_int_q;
         act_frac_d = shadow_frac_q;
         pending_d  = 1'b0;
      end
      if (bus.cfg_load) begin
         shadow_int_d  = bus.cfg_div_int;
         shadow_frac_d = bus.cfg_div_frac;
         pending_d     = 1'b1;
      end
   end

   always_comb begin
      os_cnt_d   = os_cnt_q;
      os_tick_d  = term;
      mid_tick_d = term && (os_cnt_q == OsMid);
      bit_tick_d = term && (os_cnt_q == OsLast);
      if (bus.restart) begin
         os_cnt_d = '0;
      end else if (term) begin
         os_cnt_d = (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsCntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_int_q  <= RstInt;
         shadow_frac_q <= RstFrac;
         act_int_q     <= RstInt;
         act_frac_q    <= RstFrac;
         pending_q     <= 1'b0;
         os_cnt_q      <= '0;
         os_tick_q     <= 1'b0;
         mid_tick_q    <= 1'b0;
         bit_tick_q    <= 1'b0;
      end else begin
         shadow_int_q  <= shadow_int_d;
         shadow_frac_q <= shadow_frac_d;
         act_int_q     <= act_int_d;
         act_frac_q    <= act_frac_d;
         pending_q     <= pending_d;
         os_cnt_q      <= os_cnt_d;
         os_tick_q     <= os_tick_d;
         mid_tick_q    <= mid_tick_d;
         bit_tick_q    <= bit_tick_d;
      end
   end

   assign bus.os_tick     = os_tick_q;
   assign bus.mid_tick    = mid_tick_q;
   assign bus.bit_tick    = bit_tick_q;
   assign bus.cfg_pending = pending_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick periods, mid/bit placement, restart, enable hold,
// shadow divisor hand-over and asynchronous reset.
module tb_baud_gen_frac;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   baud_gen_frac_if #(.DIV_W(16), .FRAC_W(8)) bif ();

   baud_gen_frac dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   // Counts falling edges until os_tick is seen; gives up at limit.
   task automatic wait_tick(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!bif.os_tick && cycles < limit);
   endtask

   task automatic setup_div(input int di, input int df);
      @(negedge clk);
      bif.enable       = 1'b0;
      bif.cfg_load     = 1'b1;
      bif.cfg_div_int  = 16'(di);
      bif.cfg_div_frac = 8'(df);
      @(negedge clk);
      bif.cfg_load = 1'b0;
      bif.restart  = 1'b1;
      @(negedge clk);
      bif.restart = 1'b0;
      total++;
      if (bif.cfg_pending !== 1'b0) begin
         bad++;
         $display("FAIL setup_pending: got %0b want 0", bif.cfg_pending);
      end
      bif.enable = 1'b1;
   endtask

   task automatic test_reset();
      bif.enable = 1'b1;
      bif.cfg_load = 1'b0;
      bif.restart = 1'b0;
      bif.cfg_div_int = '0;
      bif.cfg_div_frac = '0;
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({bif.os_tick, bif.mid_tick, bif.bit_tick, bif.cfg_pending} !== 4'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {bif.os_tick, bif.mid_tick, bif.bit_tick, bif.cfg_pending});
         end
      end
   endtask

   task automatic test_default_periods();
      int c;
      int exp_p[3] = '{325, 325, 326};
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_tick(1000, c);
         total++;
         if (c !== exp_p[i]) begin
            bad++;
            $display("FAIL default_period%0d: got %0d want %0d", i, c, exp_p[i]);
         end
      end
   endtask

   task automatic test_div4_ticks();
      int c;
      setup_div(4, 0);
      for (int i = 1; i <= 64; i++) begin
         wait_tick(100, c);
         total++;
         if (c !== 4) begin
            bad++;
            $display("FAIL div4_period%0d: got %0d want 4", i, c);
         end
         total++;
         if (bif.mid_tick !== ((i % 16) == 8)) begin
            bad++;
            $display("FAIL div4_mid%0d: got %0b want %0b", i, bif.mid_tick, (i % 16) == 8);
         end
         total++;
         if (bif.bit_tick !== ((i % 16) == 0)) begin
            bad++;
            $display("FAIL div4_bit%0d: got %0b want %0b", i, bif.bit_tick, (i % 16) == 0);
         end
      end
   endtask

   task automatic test_frac();
      int c;
      int sum = 0;
      int exp_p[6] = '{4, 4, 5, 4, 5, 4};
      setup_div(4, 128);
      for (int i = 0; i < 100; i++) begin
         wait_tick(100, c);
         sum += c;
         if (i < 6) begin
            total++;
            if (c !== exp_p[i]) begin
               bad++;
               $display("FAIL frac_period%0d: got %0d want %0d", i, c, exp_p[i]);
            end
         end
      end
      total++;
      if (sum !== 449) begin
         bad++;
         $display("FAIL frac_sum100: got %0d want 449", sum);
      end
   endtask

   task automatic test_restart();
      int c;
      int n;
      setup_div(4, 0);
      wait_tick(100, c);
      repeat (2) @(negedge clk);
      bif.restart = 1'b1;
      @(negedge clk);
      bif.restart = 1'b0;
      total++;
      if (bif.os_tick !== 1'b0) begin
         bad++;
         $display("FAIL restart_no_tick: got %0b want 0", bif.os_tick);
      end
      wait_tick(100, c);
      total++;
      if (c !== 4) begin
         bad++;
         $display("FAIL restart_first: got %0d want 4", c);
      end
      n = c;
      while (!bif.bit_tick && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n !== 64 || bif.os_tick !== 1'b1) begin
         bad++;
         $display("FAIL restart_bit: got %0d/%0b want 64/1", n, bif.os_tick);
      end
   endtask

   task automatic test_cfg_switch();
      int c;
      setup_div(4, 0);
      wait_tick(100, c);
      bif.cfg_load = 1'b1;
      bif.cfg_div_int = 16'd6;
      @(negedge clk);
      bif.cfg_load = 1'b0;
      total++;
      if (bif.cfg_pending !== 1'b1) begin
         bad++;
         $display("FAIL cfg_pending_set: got %0b want 1", bif.cfg_pending);
      end
      wait_tick(100, c);
      total++;
      if (c !== 3 || bif.cfg_pending !== 1'b0) begin
         bad++;
         $display("FAIL cfg_old_finish: got %0d/%0b want 3/0", c, bif.cfg_pending);
      end
      wait_tick(100, c);
      total++;
      if (c !== 6) begin
         bad++;
         $display("FAIL cfg_new_period: got %0d want 6", c);
      end
      // Strobe on the terminal edge: swap is deferred by one period.
      repeat (5) @(negedge clk);
      bif.cfg_load = 1'b1;
      bif.cfg_div_int = 16'd4;
      @(negedge clk);
      bif.cfg_load = 1'b0;
      total++;
      if (bif.os_tick !== 1'b1 || bif.cfg_pending !== 1'b1) begin
         bad++;
         $display("FAIL cfg_term_strobe: got %0b/%0b want 1/1", bif.os_tick, bif.cfg_pending);
      end
      wait_tick(100, c);
      total++;
      if (c !== 6 || bif.cfg_pending !== 1'b0) begin
         bad++;
         $display("FAIL cfg_deferred: got %0d/%0b want 6/0", c, bif.cfg_pending);
      end
      wait_tick(100, c);
      total++;
      if (c !== 4) begin
         bad++;
         $display("FAIL cfg_after_defer: got %0d want 4", c);
      end
   endtask

   task automatic test_enable_hold();
      int c;
      setup_div(4, 0);
      wait_tick(100, c);
      @(negedge clk);
      bif.enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (bif.os_tick !== 1'b0) begin
            bad++;
            $display("FAIL hold_tick%0d: got %0b want 0", i, bif.os_tick);
         end
      end
      bif.enable = 1'b1;
      wait_tick(100, c);
      total++;
      if (c !== 3) begin
         bad++;
         $display("FAIL reenable_first: got %0d want 3", c);
      end
      wait_tick(100, c);
      total++;
      if (c !== 4) begin
         bad++;
         $display("FAIL reenable_next: got %0d want 4", c);
      end
   endtask

   task automatic test_reset_mid();
      int c;
      setup_div(4, 0);
      wait_tick(100, c);
      @(negedge clk);
      bif.cfg_load = 1'b1;
      bif.cfg_div_int = 16'd6;
      @(negedge clk);
      bif.cfg_load = 1'b0;
      wait_tick(100, c);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({bif.os_tick, bif.mid_tick, bif.bit_tick, bif.cfg_pending} !== 4'b0) begin
         bad++;
         $display("FAIL async_reset: got %b want 0000",
                  {bif.os_tick, bif.mid_tick, bif.bit_tick, bif.cfg_pending});
      end
      @(negedge clk);
      reset_n = 1'b1;
      wait_tick(1000, c);
      total++;
      if (c !== 325) begin
         bad++;
         $display("FAIL reset_divisor: got %0d want 325", c);
      end
   endtask

   initial begin
      test_reset();
      test_default_periods();
      test_div4_ticks();
      test_frac();
      test_restart();
      test_cfg_switch();
      test_enable_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
